// File: rtl/srio_pkg.sv
// Shared SRIO logical-layer definitions: HELLO header layout, doorbell info codes
// and the doorbell responder state encoding.
package srio_pkg;

  localparam logic [3:0] FTYPE_DOORB  = 4'hA;
  localparam logic [3:0] FTYPE_NWRITE = 4'h5;
  localparam logic [3:0] TNWR         = 4'h4;

  localparam int TID_MSB   = 63;
  localparam int TID_LSB   = 56;
  localparam int FTYPE_MSB = 55;
  localparam int FTYPE_LSB = 52;
  localparam int TTYPE_MSB = 51;
  localparam int TTYPE_LSB = 48;
  localparam int PRIO_MSB  = 46;
  localparam int PRIO_LSB  = 45;
  localparam int SIZE_MSB  = 43;
  localparam int SIZE_LSB  = 36;
  localparam int ADDR_MSB  = 33;
  localparam int ADDR_LSB  = 0;
  localparam int INFO_MSB  = 31;
  localparam int INFO_LSB  = 16;

  localparam logic [15:0] DB_REQ_INFO   = 16'h0101;
  localparam logic [15:0] DB_READY_INFO = 16'h0100;
  localparam logic [15:0] DB_BUSY_INFO  = 16'h0102;

  typedef enum logic [1:0] {
    IDLE_s  = 2'd0,
    RESP_s  = 2'd1,
    DRAIN_s = 2'd2
  } resp_state_t;

  // Response priority is one above the request so it cannot be blocked behind it.
  function automatic logic [1:0] prio_bump(input logic [1:0] prio);
    if (prio == 2'b11) begin
      return 2'b11;
    end else begin
      return prio + 2'b01;
    end
  endfunction

endpackage

// File: rtl/srio_hdr_decode.sv
// Combinational field split of a HELLO-format header beat and its tuser word.
module srio_hdr_decode
  import srio_pkg::*;
(
  input  logic [63:0] tdata,
  input  logic [31:0] tuser,
  output logic [7:0]  tid,
  output logic [3:0]  ftype,
  output logic [3:0]  ttype,
  output logic [1:0]  prio,
  output logic [7:0]  size,
  output logic [33:0] addr,
  output logic [15:0] info,
  output logic [15:0] src,
  output logic [15:0] dst
);

  logic unused_rsvd_s;

  assign tid   = tdata[TID_MSB:TID_LSB];
  assign ftype = tdata[FTYPE_MSB:FTYPE_LSB];
  assign ttype = tdata[TTYPE_MSB:TTYPE_LSB];
  assign prio  = tdata[PRIO_MSB:PRIO_LSB];
  assign size  = tdata[SIZE_MSB:SIZE_LSB];
  assign addr  = tdata[ADDR_MSB:ADDR_LSB];
  assign info  = tdata[INFO_MSB:INFO_LSB];
  assign src   = tuser[31:16];
  assign dst   = tuser[15:0];

  assign unused_rsvd_s = ^{tdata[47], tdata[44], tdata[35:34]};

endmodule

// File: rtl/db_target_resp.sv
// Target-side doorbell responder: answers self-check doorbells with READY/BUSY,
// drains and counts every other inbound packet.
module db_target_resp
  import srio_pkg::*;
#(
  parameter logic [15:0] REQ_INFO   = DB_REQ_INFO,
  parameter logic [15:0] READY_INFO = DB_READY_INFO,
  parameter logic [15:0] BUSY_INFO  = DB_BUSY_INFO,
  parameter int          CNT_W      = 16
) (
  input  logic             log_clk,
  input  logic             log_rst_n,
  input  logic [15:0]      src_id,
  input  logic             link_initialized,
  input  logic             busy_in,
  input  logic             treq_tvalid,
  output logic             treq_tready,
  input  logic             treq_tlast,
  input  logic [63:0]      treq_tdata,
  input  logic [7:0]       treq_tkeep,
  input  logic [31:0]      treq_tuser,
  output logic             ireq_tvalid_o,
  input  logic             ireq_tready_in,
  output logic             ireq_tlast_o,
  output logic [63:0]      ireq_tdata_o,
  output logic [7:0]       ireq_tkeep_o,
  output logic [31:0]      ireq_tuser_o,
  output logic             db_rcvd_o,
  output logic [15:0]      db_req_id_o,
  output logic [CNT_W-1:0] db_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  resp_state_t state_r;

  logic [7:0]  hdr_tid_s;
  logic [3:0]  hdr_ftype_s;
  logic [3:0]  hdr_ttype_s;
  logic [1:0]  hdr_prio_s;
  logic [7:0]  hdr_size_s;
  logic [33:0] hdr_addr_s;
  logic [15:0] hdr_info_s;
  logic [15:0] hdr_src_s;
  logic [15:0] hdr_dst_s;
  logic        accept_s;
  logic        valid_req_s;
  logic        unused_s;

  srio_hdr_decode u_hdr_decode (
    .tdata (treq_tdata),
    .tuser (treq_tuser),
    .tid   (hdr_tid_s),
    .ftype (hdr_ftype_s),
    .ttype (hdr_ttype_s),
    .prio  (hdr_prio_s),
    .size  (hdr_size_s),
    .addr  (hdr_addr_s),
    .info  (hdr_info_s),
    .src   (hdr_src_s),
    .dst   (hdr_dst_s)
  );

  assign unused_s = ^{treq_tkeep, hdr_ttype_s, hdr_size_s, hdr_addr_s};

  // treq is only held off while a response is outstanding or the link is down.
  assign treq_tready = link_initialized & (state_r != RESP_s);
  assign accept_s    = treq_tvalid & treq_tready;
  assign valid_req_s = (hdr_ftype_s == FTYPE_DOORB) && (hdr_info_s == REQ_INFO) &&
                       (hdr_dst_s == src_id) && treq_tlast;

  // Responder FSM; the ireq registers themselves hold the latched request fields.
  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) begin
      state_r       <= IDLE_s;
      ireq_tvalid_o <= 1'b0;
      ireq_tlast_o  <= 1'b0;
      ireq_tdata_o  <= 64'h0;
      ireq_tkeep_o  <= 8'h00;
      ireq_tuser_o  <= 32'h0;
      db_rcvd_o     <= 1'b0;
      db_req_id_o   <= 16'h0000;
      db_cnt_o      <= {CNT_W{1'b0}};
      drop_cnt_o    <= {CNT_W{1'b0}};
    end else begin
      db_rcvd_o <= 1'b0;
      case (state_r)
        IDLE_s: begin
          if (accept_s) begin
            if (valid_req_s) begin
              ireq_tvalid_o <= 1'b1;
              ireq_tlast_o  <= 1'b1;
              ireq_tkeep_o  <= 8'hFF;
              ireq_tuser_o  <= {src_id, hdr_src_s};
              ireq_tdata_o  <= {hdr_tid_s, FTYPE_DOORB, 4'h0, 1'b0, prio_bump(hdr_prio_s),
                                1'b0, 12'h000, (busy_in ? BUSY_INFO : READY_INFO), 16'h0000};
              db_rcvd_o     <= 1'b1;
              db_req_id_o   <= hdr_src_s;
              db_cnt_o      <= (db_cnt_o == CNT_MAX) ? db_cnt_o : db_cnt_o + CNT_ONE;
              state_r       <= RESP_s;
            end else begin
              drop_cnt_o <= (drop_cnt_o == CNT_MAX) ? drop_cnt_o : drop_cnt_o + CNT_ONE;
              state_r    <= treq_tlast ? IDLE_s : DRAIN_s;
            end
          end
        end
        RESP_s: begin
          if (ireq_tready_in) begin
            ireq_tvalid_o <= 1'b0;
            ireq_tlast_o  <= 1'b0;
            ireq_tdata_o  <= 64'h0;
            ireq_tkeep_o  <= 8'h00;
            ireq_tuser_o  <= 32'h0;
            state_r       <= IDLE_s;
          end
        end
        DRAIN_s: begin
          if (accept_s && treq_tlast) begin
            state_r <= IDLE_s;
          end
        end
        default: begin
          ireq_tvalid_o <= 1'b0;
          ireq_tlast_o  <= 1'b0;
          ireq_tdata_o  <= 64'h0;
          ireq_tkeep_o  <= 8'h00;
          ireq_tuser_o  <= 32'h0;
          state_r       <= IDLE_s;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_db_target_resp.sv
// Self-checking bench for db_target_resp with a transaction-level reference model.
module tb_db_target_resp;

  localparam int          CW    = 4;
  localparam int          CMAX  = 15;
  localparam logic [15:0] MY_ID = 16'h00F0;

  logic          log_clk = 1'b0;
  logic          log_rst_n = 1'b0;
  logic [15:0]   src_id = MY_ID;
  logic          link_initialized = 1'b1;
  logic          busy_in = 1'b0;
  logic          treq_tvalid = 1'b0;
  logic          treq_tready;
  logic          treq_tlast = 1'b0;
  logic [63:0]   treq_tdata = 64'h0;
  logic [7:0]    treq_tkeep = 8'hFF;
  logic [31:0]   treq_tuser = 32'h0;
  logic          ireq_tvalid_o;
  logic          ireq_tready_in = 1'b0;
  logic          ireq_tlast_o;
  logic [63:0]   ireq_tdata_o;
  logic [7:0]    ireq_tkeep_o;
  logic [31:0]   ireq_tuser_o;
  logic          db_rcvd_o;
  logic [15:0]   db_req_id_o;
  logic [CW-1:0] db_cnt_o;
  logic [CW-1:0] drop_cnt_o;

  int checks = 0;
  int failures = 0;
  int exp_db = 0;
  int exp_drop = 0;
  int exp_pulses = 0;
  int seen_pulses = 0;
  logic [15:0] exp_last_id = 16'h0000;

  db_target_resp #(.CNT_W(CW)) dut (
    .log_clk(log_clk), .log_rst_n(log_rst_n), .src_id(src_id),
    .link_initialized(link_initialized), .busy_in(busy_in),
    .treq_tvalid(treq_tvalid), .treq_tready(treq_tready), .treq_tlast(treq_tlast),
    .treq_tdata(treq_tdata), .treq_tkeep(treq_tkeep), .treq_tuser(treq_tuser),
    .ireq_tvalid_o(ireq_tvalid_o), .ireq_tready_in(ireq_tready_in),
    .ireq_tlast_o(ireq_tlast_o), .ireq_tdata_o(ireq_tdata_o), .ireq_tkeep_o(ireq_tkeep_o),
    .ireq_tuser_o(ireq_tuser_o), .db_rcvd_o(db_rcvd_o), .db_req_id_o(db_req_id_o),
    .db_cnt_o(db_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 log_clk = ~log_clk;

  always @(negedge log_clk) if (db_rcvd_o === 1'b1) seen_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [63:0] mk_hdr(input logic [7:0] tid, input logic [3:0] ft,
                                         input logic [1:0] pr, input logic [15:0] info);
    return {tid, ft, 4'h0, 1'b0, pr, 1'b0, 12'h000, info, 16'h0000};
  endfunction

  function automatic logic [63:0] model_resp(input logic [7:0] tid, input logic [1:0] pr,
                                             input logic busy);
    int rp;
    logic [15:0] inf;
    rp  = (int'(pr) == 3) ? 3 : int'(pr) + 1;
    inf = busy ? 16'h0102 : 16'h0100;
    return (64'(tid) << 56) | (64'hA << 52) | (64'(rp) << 45) | (64'(inf) << 16);
  endfunction

  function automatic int sat(input int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  task automatic tick();
    @(posedge log_clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; waited reports stall cycles.
  task automatic drive_beat(input logic [63:0] d, input logic [31:0] u, input logic last,
                            output int waited);
    int budget = 50;
    treq_tvalid = 1'b1; treq_tdata = d; treq_tuser = u; treq_tlast = last;
    #1;
    waited = 0;
    while (treq_tready !== 1'b1 && budget > 0) begin
      tick(); budget--; waited++;
    end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL beat_accept_timeout got tready=%b exp 1", treq_tready);
    end
    tick();
    treq_tvalid = 1'b0;
  endtask

  task automatic finish_resp(input int stall, input logic [63:0] exp_d, input logic [31:0] exp_u);
    ireq_tready_in = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      checks++;
      if ({ireq_tvalid_o, treq_tready, ireq_tdata_o, ireq_tuser_o} !== {1'b1, 1'b0, exp_d, exp_u}) begin
        failures++;
        $display("FAIL resp_hold got v=%b rdy=%b d=%h u=%h exp v=1 rdy=0 d=%h u=%h",
                 ireq_tvalid_o, treq_tready, ireq_tdata_o, ireq_tuser_o, exp_d, exp_u);
      end
    end
    ireq_tready_in = 1'b1;
    tick();
    ireq_tready_in = 1'b0;
    checks++;
    if ({ireq_tvalid_o, ireq_tlast_o, ireq_tkeep_o, ireq_tdata_o, ireq_tuser_o, db_rcvd_o} !== 106'h0) begin
      failures++;
      $display("FAIL resp_clear got v=%b l=%b k=%h d=%h u=%h rcvd=%b exp all 0",
               ireq_tvalid_o, ireq_tlast_o, ireq_tkeep_o, ireq_tdata_o, ireq_tuser_o, db_rcvd_o);
    end
    checks++;
    if (treq_tready !== link_initialized) begin
      failures++;
      $display("FAIL idle_tready got %b exp %b", treq_tready, link_initialized);
    end
  endtask

  task automatic run_pkt(input logic [7:0] tid, input logic [3:0] ft, input logic [1:0] pr,
                         input logic [15:0] info, input logic [15:0] rsrc, input logic [15:0] rdst,
                         input int nbeats, input logic busy, input int stall);
    bit valid;
    int w;
    logic [63:0] exp_d;
    valid = (ft == 4'hA) && (info == 16'h0101) && (rdst == MY_ID) && (nbeats == 1);
    busy_in = busy;
    drive_beat(mk_hdr(tid, ft, pr, info), {rsrc, rdst}, nbeats == 1, w);
    busy_in = ~busy;
    if (valid) begin
      exp_db = sat(exp_db); exp_pulses++; exp_last_id = rsrc;
      exp_d = model_resp(tid, pr, busy);
      checks++;
      if (ireq_tdata_o !== exp_d) begin
        failures++;
        $display("FAIL resp_tdata got %h exp %h", ireq_tdata_o, exp_d);
      end
      checks++;
      if ({ireq_tvalid_o, ireq_tlast_o, ireq_tkeep_o, ireq_tuser_o} !== {1'b1, 1'b1, 8'hFF, MY_ID, rsrc}) begin
        failures++;
        $display("FAIL resp_ctrl got v=%b l=%b k=%h u=%h exp v=1 l=1 k=ff u=%h%h",
                 ireq_tvalid_o, ireq_tlast_o, ireq_tkeep_o, ireq_tuser_o, MY_ID, rsrc);
      end
      checks++;
      if ({db_rcvd_o, db_req_id_o, db_cnt_o, treq_tready} !== {1'b1, exp_last_id, CW'(exp_db), 1'b0}) begin
        failures++;
        $display("FAIL req_status got rcvd=%b id=%h cnt=%0d rdy=%b exp rcvd=1 id=%h cnt=%0d rdy=0",
                 db_rcvd_o, db_req_id_o, db_cnt_o, treq_tready, exp_last_id, exp_db);
      end
      finish_resp(stall, exp_d, {MY_ID, rsrc});
    end else begin
      exp_drop = sat(exp_drop);
      for (int b = 1; b < nbeats; b++) begin
        drive_beat({$urandom, $urandom}, $urandom, b == nbeats - 1, w);
        checks++;
        if ({w, ireq_tvalid_o} !== {32'd0, 1'b0}) begin
          failures++;
          $display("FAIL drain_beat got waited=%0d ireq_v=%b exp 0 0", w, ireq_tvalid_o);
        end
      end
      checks++;
      if ({drop_cnt_o, db_cnt_o, ireq_tvalid_o, db_rcvd_o, treq_tready} !==
          {CW'(exp_drop), CW'(exp_db), 1'b0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL drop_status got drop=%0d db=%0d v=%b rcvd=%b rdy=%b exp drop=%0d db=%0d v=0 rcvd=0 rdy=1",
                 drop_cnt_o, db_cnt_o, ireq_tvalid_o, db_rcvd_o, treq_tready, exp_drop, exp_db);
      end
    end
  endtask

  task automatic test_reset();
    log_rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({ireq_tvalid_o, ireq_tlast_o, ireq_tkeep_o, ireq_tdata_o, ireq_tuser_o, db_rcvd_o,
         db_req_id_o, db_cnt_o, drop_cnt_o} !== 130'h0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h u=%h id=%h db=%0d drop=%0d exp all 0",
               ireq_tvalid_o, ireq_tdata_o, ireq_tuser_o, db_req_id_o, db_cnt_o, drop_cnt_o);
    end
    log_rst_n = 1'b1;
    tick();
    checks++;
    if (treq_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_tready got %b exp 1", treq_tready);
    end
  endtask

  task automatic test_ready_req();
    run_pkt(8'h05, 4'hA, 2'b01, 16'h0101, 16'h00AB, MY_ID, 1, 1'b0, 0);
  endtask

  task automatic test_busy_req();
    run_pkt(8'h05, 4'hA, 2'b11, 16'h0101, 16'h00AB, MY_ID, 1, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    int w;
    logic [63:0] d1;
    busy_in = 1'b0;
    drive_beat(mk_hdr(8'h21, 4'hA, 2'b00, 16'h0101), {16'h0033, MY_ID}, 1'b1, w);
    exp_db = sat(exp_db); exp_pulses++; exp_last_id = 16'h0033;
    d1 = model_resp(8'h21, 2'b00, 1'b0);
    checks++;
    if ({ireq_tvalid_o, ireq_tdata_o} !== {1'b1, d1}) begin
      failures++;
      $display("FAIL b2b_first got v=%b d=%h exp v=1 d=%h", ireq_tvalid_o, ireq_tdata_o, d1);
    end
    treq_tvalid = 1'b1; treq_tlast = 1'b1;
    treq_tdata = mk_hdr(8'h22, 4'hA, 2'b01, 16'h0101); treq_tuser = {16'h0044, MY_ID};
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ireq_tvalid_o, ireq_tdata_o, treq_tready, db_cnt_o} !== {1'b1, d1, 1'b0, CW'(exp_db)}) begin
        failures++;
        $display("FAIL b2b_stall got v=%b d=%h rdy=%b cnt=%0d exp v=1 d=%h rdy=0 cnt=%0d",
                 ireq_tvalid_o, ireq_tdata_o, treq_tready, db_cnt_o, d1, exp_db);
      end
    end
    ireq_tready_in = 1'b1;
    tick();
    checks++;
    if ({ireq_tvalid_o, treq_tready, db_cnt_o} !== {1'b0, 1'b1, CW'(exp_db)}) begin
      failures++;
      $display("FAIL b2b_handshake got v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=%0d",
               ireq_tvalid_o, treq_tready, db_cnt_o, exp_db);
    end
    tick();
    treq_tvalid = 1'b0;
    exp_db = sat(exp_db); exp_pulses++; exp_last_id = 16'h0044;
    checks++;
    if ({ireq_tvalid_o, ireq_tdata_o, db_cnt_o, db_req_id_o} !==
        {1'b1, model_resp(8'h22, 2'b01, 1'b0), CW'(exp_db), exp_last_id}) begin
      failures++;
      $display("FAIL b2b_second got v=%b d=%h cnt=%0d id=%h exp v=1 d=%h cnt=%0d id=%h", ireq_tvalid_o,
               ireq_tdata_o, db_cnt_o, db_req_id_o, model_resp(8'h22, 2'b01, 1'b0), exp_db, exp_last_id);
    end
    tick();
    ireq_tready_in = 1'b0;
    checks++;
    if (ireq_tvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_clear got %b exp 0", ireq_tvalid_o);
    end
  endtask

  task automatic test_backpressure();
    run_pkt(8'h3C, 4'hA, 2'b10, 16'h0101, 16'h0077, MY_ID, 1, 1'b1, 5);
  endtask

  task automatic test_nwrite_drain();
    run_pkt(8'h40, 4'h5, 2'b00, 16'h1234, 16'h00AB, MY_ID, 4, 1'b0, 0);
  endtask

  task automatic test_bad_doorbell();
    run_pkt(8'h41, 4'hA, 2'b00, 16'h0200, 16'h00AB, MY_ID, 1, 1'b0, 0);
    run_pkt(8'h42, 4'hA, 2'b00, 16'h0101, 16'h00AB, 16'h0011, 1, 1'b0, 0);
    run_pkt(8'h43, 4'hA, 2'b00, 16'h0101, 16'h00AB, MY_ID, 2, 1'b0, 0);
  endtask

  task automatic test_link_drop();
    int w;
    drive_beat(mk_hdr(8'h50, 4'h5, 2'b00, 16'h0000), {16'h00AB, MY_ID}, 1'b0, w);
    exp_drop = sat(exp_drop);
    link_initialized = 1'b0;
    treq_tvalid = 1'b1; treq_tlast = 1'b0; treq_tdata = 64'h1111; treq_tuser = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (treq_tready !== 1'b0) begin
        failures++;
        $display("FAIL drain_link_down got tready=%b exp 0", treq_tready);
      end
    end
    link_initialized = 1'b1;
    drive_beat(64'h1111, 32'h0, 1'b0, w);
    drive_beat(64'h2222, 32'h0, 1'b1, w);
    checks++;
    if ({drop_cnt_o, treq_tready} !== {CW'(exp_drop), 1'b1}) begin
      failures++;
      $display("FAIL drain_resume got drop=%0d rdy=%b exp drop=%0d rdy=1", drop_cnt_o, treq_tready, exp_drop);
    end
    busy_in = 1'b0;
    drive_beat(mk_hdr(8'h51, 4'hA, 2'b00, 16'h0101), {16'h0055, MY_ID}, 1'b1, w);
    exp_db = sat(exp_db); exp_pulses++; exp_last_id = 16'h0055;
    link_initialized = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ireq_tvalid_o, ireq_tdata_o} !== {1'b1, model_resp(8'h51, 2'b00, 1'b0)}) begin
        failures++;
        $display("FAIL resp_link_down got v=%b d=%h exp v=1 d=%h", ireq_tvalid_o, ireq_tdata_o,
                 model_resp(8'h51, 2'b00, 1'b0));
      end
    end
    finish_resp(0, model_resp(8'h51, 2'b00, 1'b0), {MY_ID, 16'h0055});
    link_initialized = 1'b1;
    #1;
  endtask

  task automatic test_random();
    int kind, nb;
    logic [15:0] info, dst;
    logic [3:0] ft;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 5);
      ft = 4'hA; info = 16'h0101; dst = MY_ID; nb = 1;
      case (kind)
        2: begin info = 16'($urandom); if (info == 16'h0101) info = 16'h0200; end
        3: begin dst = 16'($urandom); if (dst == MY_ID) dst = 16'h0011; end
        4: begin ft = 4'h5; nb = $urandom_range(1, 4); end
        5: nb = $urandom_range(2, 3);
        default: ;
      endcase
      run_pkt(8'($urandom), ft, 2'($urandom), info, 16'($urandom), dst, nb,
              1'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < CMAX + 3; n++) begin
      run_pkt(8'(n), 4'hA, 2'b00, 16'h0101, 16'(n + 1), MY_ID, 1, 1'b0, 0);
      run_pkt(8'(n), 4'h5, 2'b00, 16'h0000, 16'h0001, MY_ID, 1, 1'b0, 0);
    end
  endtask

  task automatic test_reset_mid_resp();
    int w;
    busy_in = 1'b1;
    drive_beat(mk_hdr(8'h66, 4'hA, 2'b01, 16'h0101), {16'h0099, MY_ID}, 1'b1, w);
    exp_pulses++;
    tick();
    #2 log_rst_n = 1'b0;
    #1;
    exp_db = 0; exp_drop = 0; exp_last_id = 16'h0000;
    checks++;
    if ({ireq_tvalid_o, ireq_tlast_o, ireq_tkeep_o, ireq_tdata_o, ireq_tuser_o, db_rcvd_o,
         db_req_id_o, db_cnt_o, drop_cnt_o} !== 130'h0) begin
      failures++;
      $display("FAIL async_reset got v=%b d=%h u=%h id=%h db=%0d drop=%0d exp all 0",
               ireq_tvalid_o, ireq_tdata_o, ireq_tuser_o, db_req_id_o, db_cnt_o, drop_cnt_o);
    end
    tick();
    link_initialized = 1'b0;
    log_rst_n = 1'b1;
    #1;
    checks++;
    if (treq_tready !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_link_down got %b exp 0", treq_tready);
    end
    link_initialized = 1'b1;
    #1;
    checks++;
    if (treq_tready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_link_up got %b exp 1", treq_tready);
    end
    ireq_tready_in = 1'b1;
    tick(); tick();
    ireq_tready_in = 1'b0;
    checks++;
    if (ireq_tvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL no_resend got %b exp 0", ireq_tvalid_o);
    end
  endtask

  initial begin
    test_reset();
    test_ready_req();
    test_busy_req();
    test_backpressure();
    test_back_to_back();
    test_nwrite_drain();
    test_bad_doorbell();
    test_link_drop();
    test_random();
    test_saturation();
    test_reset_mid_resp();
    tick();
    checks++;
    if (seen_pulses !== exp_pulses) begin
      failures++;
      $display("FAIL rcvd_pulse_count got %0d exp %0d", seen_pulses, exp_pulses);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/db_target_resp.md
Name: db_target_resp

Overview:
- Target-side doorbell responder; sits on the SRIO logical layer of the remote endpoint.
- Consumes the doorbell requests our doorbell initiator sends, on the core's target-request (treq) AXI-Stream.
- Answers each valid request with a single-beat READY or BUSY doorbell on the initiator-request (ireq) AXI-Stream.
- Drains and counts every other inbound packet so treq never stalls.

Parameters:
- REQ_INFO, 16'h0101, doorbell info field that identifies a self-check request
- READY_INFO, 16'h0100, info field returned when busy_in=0
- BUSY_INFO, 16'h0102, info field returned when busy_in=1
- CNT_W, 16, width of the saturating status counters

Ports:
- log_clk  in  1  logical-layer clock
- log_rst_n  in  1  asynchronous active-low reset
- src_id  in  16  this endpoint's device ID
- link_initialized  in  1  SRIO link up
- busy_in  in  1  local busy status, sampled at header accept
- treq_tvalid  in  1  target request valid
- treq_tready  out  1  target request ready
- treq_tlast  in  1  last beat
- treq_tdata  in  64  HELLO-format beat
- treq_tkeep  in  8  byte enables (ignored)
- treq_tuser  in  32  {src_id, dest_id} of the request
- ireq_tvalid_o  out  1  response doorbell valid
- ireq_tready_in  in  1  core ready
- ireq_tlast_o  out  1  last beat
- ireq_tdata_o  out  64  response header
- ireq_tkeep_o  out  8  byte enables
- ireq_tuser_o  out  32  {src_id, requester id}
- db_rcvd_o  out  1  one-cycle pulse per accepted request
- db_req_id_o  out  16  source ID of the last accepted request
- db_cnt_o  out  CNT_W  accepted doorbell requests, saturating
- drop_cnt_o  out  CNT_W  dropped packets, saturating

Behaviour:
- Reset (log_rst_n=0, asynchronous): state IDLE_s; all ireq_* outputs 0; db_rcvd_o 0; db_req_id_o 0; both counters 0.
- treq_tready = link_initialized and (state is IDLE_s or DRAIN_s). It is 0 in RESP_s.
- Header fields (first beat only): tid = [63:56]; ftype = [55:52]; prio = [46:45]; info = [31:16]; req_src = treq_tuser[31:16]; req_dst = treq_tuser[15:0].
- Valid request: ftype == 4'hA, info == REQ_INFO, req_dst == src_id, and tlast = 1 on the same beat.
- IDLE_s, on a header beat (tvalid & tready):
  - Valid request: latch tid, prio and req_src; latch busy_in; pulse db_rcvd_o; update db_req_id_o; increment db_cnt_o; go to RESP_s.
  - Otherwise with tlast = 1: increment drop_cnt_o; stay in IDLE_s.
  - Otherwise with tlast = 0: increment drop_cnt_o; go to DRAIN_s.
- DRAIN_s: accept beats unconditionally. On the tlast beat, go to IDLE_s. The whole packet counts as one drop.
- RESP_s:
  - ireq_tvalid_o rises on the cycle after the header is accepted (latency 1).
  - ireq_tdata_o = {tid, 4'hA, 4'h0, 1'b0, rprio, 1'b0, 12'h000, info_out, 16'h0000}.
  - rprio = prio+1, saturating at 2'b11.
  - info_out = BUSY_INFO if the latched busy = 1, else READY_INFO.
  - ireq_tkeep_o = 8'hFF; ireq_tlast_o = 1; ireq_tuser_o = {src_id, latched req_src}.
  - All ireq outputs hold stable until ireq_tready_in = 1. On that handshake cycle: go to IDLE_s; ireq_tvalid_o, tlast, tkeep, tdata and tuser clear to 0 on the following cycle.
- Back-to-back requests: the next header can be accepted no earlier than the cycle after the ireq handshake (treq_tready is 0 throughout RESP_s).
- Link drop in RESP_s: keep ireq_tvalid_o asserted until handshake (AXI rule). Link drop in DRAIN_s: stall (tready = 0); resume draining when the link returns.
- Counter saturation: both counters stop at all-ones with no wrap. db_rcvd_o still pulses at saturation.
- Reset mid-response: outputs clear immediately. No partial beat is resent after reset.

Decomposition:
- Shared package srio_pkg holds:
  - FTYPE constants (DOORB = 4'hA, NWRITE = 4'h5), TNWR = 4'h4
  - HELLO header field bit positions
  - Default doorbell info codes (REQ/READY/BUSY)
  - State encoding (IDLE_s, RESP_s, DRAIN_s)
- One sub-module, srio_hdr_decode: a purely combinational split of tdata/tuser into tid, ftype, ttype, prio, size, addr, info, src and dst. It is reused by the initiator's response path.

Test Plan:
- Request with src_id = 16'h00F0, tuser = {16'h00AB, 16'h00F0}, tdata = {8'h05, 4'hA, 4'h0, 1'b0, 2'b01, 1'b0, 12'h0, 16'h0101, 16'h0}, tlast = 1, busy_in = 0, ireq_tready_in = 1 -> next cycle ireq_tdata_o = {8'h05, 4'hA, 4'h0, 1'b0, 2'b10, 1'b0, 12'h0, 16'h0100, 16'h0}, ireq_tuser_o = 32'h00F0_00AB; db_cnt_o = 1; db_rcvd_o pulses once.
- Same request with busy_in = 1 and prio = 2'b11 -> info 16'h0102, rprio 2'b11.
- ireq_tready_in held 0 for 5 cycles -> ireq_* stable for 6 cycles; treq_tready = 0 throughout; a second request is accepted only after the handshake.
- 4-beat NWRITE (ftype 5) -> all 4 beats accepted back-to-back; drop_cnt_o = 1; no ireq activity.
- Doorbell with info 16'h0200, or dest 16'h0011 != src_id -> dropped; drop_cnt_o increments; db_cnt_o unchanged.
- log_rst_n asserted while ireq_tvalid_o = 1 -> all outputs 0 asynchronously; after release, treq_tready follows link_initialized in IDLE_s.
